// File: rtl/mm_core_p.sv
// Multi-cycle processor core: 8 GPRs, MAC accumulator, req/gnt data port. Optional build macro: MM_CORE_MAC_SAT_EN.
// Latency: ALU/jump 3 cycles, ST 4 + gnt wait, LD 5 + gnt wait + rvalid wait.
// Backpressure: holds in MEM until dm_gnt and in WB until dm_rvalid; status pauses only at FETCH.
module mm_core_p #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int CORE_ID = 0,
  parameter int ID_W    = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [1:0]          status,
  input  logic [15:0]         im_data,
  output logic [ADDR_W-1:0]   pc_out,
  output logic                dm_req,
  output logic                dm_we,
  output logic [ADDR_W-1:0]   dm_addr,
  output logic [DATA_W-1:0]   dm_wdata,
  input  logic                dm_gnt,
  input  logic [DATA_W-1:0]   dm_rdata,
  input  logic                dm_rvalid,
  output logic [2*DATA_W-1:0] acc_out,
  output logic [ID_W-1:0]     core_id,
  output logic                end_process
);

  localparam int AW2 = 2 * DATA_W;

  localparam logic [3:0] OP_LDI = 4'h1, OP_LD  = 4'h2, OP_ST  = 4'h3, OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5, OP_MUL = 4'h6, OP_MAC = 4'h7, OP_INC = 4'h8;
  localparam logic [3:0] OP_DEC = 4'h9, OP_JNZ = 4'hA, OP_JMP = 4'hB, OP_MVA = 4'hC;
  localparam logic [3:0] OP_CLA = 4'hD, OP_END = 4'hF;

  localparam logic [DATA_W-1:0] ONE_D = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
    MEM = 3'd4, WB = 3'd5, HALT = 3'd6
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] regs [8];
  logic [AW2-1:0]    acc;
  logic [15:0]       ir;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] dm_addr_q;
  logic [DATA_W-1:0] dm_wdata_q;

  logic [3:0]  op;
  logic [2:0]  rd, rs;
  logic [DATA_W-1:0] rd_val, rs_val;
  logic [DATA_W+8:0] imm_wide;
  logic [ADDR_W+8:0] jmp_wide;
  logic [ADDR_W+DATA_W-1:0] addr_wide;
  logic [AW2-1:0] prod;
  logic [AW2:0]   mac_sum;
  logic [AW2-1:0] acc_nxt;
  logic           soft_clr;

  assign op     = ir[15:12];
  assign rd     = ir[11:9];
  assign rs     = ir[8:6];
  assign rd_val = regs[rd];
  assign rs_val = regs[rs];

  // Zero-extend through a wide temporary so the same code works for any width.
  assign imm_wide  = {{DATA_W{1'b0}}, ir[8:0]};
  assign jmp_wide  = {{ADDR_W{1'b0}}, ir[8:0]};
  assign addr_wide = {{ADDR_W{1'b0}}, rs_val};

  assign prod    = {{DATA_W{1'b0}}, rd_val} * {{DATA_W{1'b0}}, rs_val};
  assign mac_sum = {1'b0, acc} + {1'b0, prod};
`ifdef MM_CORE_MAC_SAT_EN
  assign acc_nxt = mac_sum[AW2] ? {AW2{1'b1}} : mac_sum[AW2-1:0];
`else
  assign acc_nxt = mac_sum[AW2-1:0];
`endif

  // Soft clear is only honoured at an instruction boundary or when halted.
  assign soft_clr = ((state == FETCH) || (state == HALT)) && (status == 2'b11);

  assign pc_out      = pc;
  assign dm_req      = (state == MEM);
  assign dm_we       = (state == MEM) && (op == OP_ST);
  assign dm_addr     = dm_addr_q;
  assign dm_wdata    = dm_wdata_q;
  assign acc_out     = acc;
  assign core_id     = ID_W'(CORE_ID);
  assign end_process = (state == HALT);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (status == 2'b01) state_nxt = FETCH;
      FETCH: begin
        if (status == 2'b01)      state_nxt = DECODE;
        else if (status == 2'b11) state_nxt = IDLE;
      end
      DECODE: state_nxt = EXEC;
      EXEC: begin
        if ((op == OP_LD) || (op == OP_ST)) state_nxt = MEM;
        else if (op == OP_END)              state_nxt = HALT;
        else                                state_nxt = FETCH;
      end
      MEM:    if (dm_gnt) state_nxt = (op == OP_ST) ? FETCH : WB;
      WB:     if (dm_rvalid) state_nxt = FETCH;
      HALT:   if (status == 2'b11) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: instruction latch, PC, register file, accumulator, memory address/data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc         <= '0;
      acc        <= '0;
      ir         <= '0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (soft_clr) begin
      pc  <= '0;
      acc <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      case (state)
        DECODE: begin
          ir <= im_data;
          pc <= pc + ONE_A;
        end
        EXEC: begin
          case (op)
            OP_LDI: regs[rd] <= imm_wide[DATA_W-1:0];
            OP_LD, OP_ST: begin
              dm_addr_q  <= addr_wide[ADDR_W-1:0];
              dm_wdata_q <= rd_val;
            end
            OP_ADD: regs[rd] <= rd_val + rs_val;
            OP_SUB: regs[rd] <= rd_val - rs_val;
            OP_MUL: regs[rd] <= prod[DATA_W-1:0];
            OP_MAC: acc <= acc_nxt;
            OP_INC: regs[rd] <= rd_val + ONE_D;
            OP_DEC: regs[rd] <= rd_val - ONE_D;
            OP_JNZ: if (rd_val != '0) pc <= jmp_wide[ADDR_W-1:0];
            OP_JMP: pc <= jmp_wide[ADDR_W-1:0];
            OP_MVA: regs[rd] <= acc[DATA_W-1:0];
            OP_CLA: acc <= '0;
            default: ;
          endcase
        end
        WB: if (dm_rvalid) regs[rd] <= dm_rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_core_p.sv
// Directed bench for mm_core_p: table of single-op programs plus hand sequences.
// Instruction memory is combinational on pc_out; data memory is a req/gnt responder with programmable delays.
// Responder drives on the falling edge; all checks sample on the falling edge.
module tb_mm_core_p;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [1:0]  status;
  logic [15:0] im_data;
  logic [15:0] pc_out;
  logic        dm_req, dm_we;
  logic [15:0] dm_addr, dm_wdata;
  logic        dm_gnt;
  logic [15:0] dm_rdata;
  logic        dm_rvalid;
  logic [31:0] acc_out;
  logic [1:0]  core_id;
  logic        end_process;

  // 8-bit data-width instance for accumulator overflow behaviour.
  logic [1:0]  status8;
  logic [15:0] im_data8;
  logic [15:0] pc_out8;
  logic        dm_req8, dm_we8;
  logic [15:0] dm_addr8;
  logic [7:0]  dm_wdata8;
  logic [15:0] acc_out8;
  logic [1:0]  core_id8;
  logic        end_process8;

  logic [15:0] prog  [256];
  logic [15:0] prog8 [16];
  logic [15:0] mem   [256];

  int checks = 0;
  int errors = 0;

  int gnt_dly = 0;
  int rv_dly  = 0;
  int wr_cnt  = 0;
  int unstable = 0;
  logic [15:0] wr_addr, wr_data, rd_pc;

  bit  rec_en = 1'b0;
  int  ntr = 0;
  logic [15:0] trace [16];

  always #5 clock = ~clock;

  assign im_data  = prog[pc_out[7:0]];
  assign im_data8 = prog8[pc_out8[3:0]];

  mm_core_p #(.DATA_W(16), .ADDR_W(16), .CORE_ID(2), .ID_W(2)) dut (
    .clock(clock), .reset_n(reset_n), .status(status), .im_data(im_data),
    .pc_out(pc_out), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rdata(dm_rdata), .dm_rvalid(dm_rvalid),
    .acc_out(acc_out), .core_id(core_id), .end_process(end_process)
  );

  mm_core_p #(.DATA_W(8), .ADDR_W(16), .CORE_ID(1), .ID_W(2)) dut8 (
    .clock(clock), .reset_n(reset_n), .status(status8), .im_data(im_data8),
    .pc_out(pc_out8), .dm_req(dm_req8), .dm_we(dm_we8), .dm_addr(dm_addr8),
    .dm_wdata(dm_wdata8), .dm_gnt(1'b0), .dm_rdata(8'h00), .dm_rvalid(1'b0),
    .acc_out(acc_out8), .core_id(core_id8), .end_process(end_process8)
  );

  // Record the address of every instruction as it is decoded.
  always @(negedge clock) begin
    if (rec_en && (dut.state == S_DECODE) && (ntr < 16)) begin
      trace[ntr] = pc_out;
      ntr = ntr + 1;
    end
  end

  // Data-memory responder: grant after gnt_dly cycles, read data after rv_dly more.
  initial begin : responder
    logic [15:0] a, d, p;
    logic w;
    bit ok;
    dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0;
    forever begin
      @(negedge clock);
      if (dm_req === 1'b1) begin
        a = dm_addr; d = dm_wdata; w = dm_we; p = pc_out; ok = 1'b1;
        for (int k = 0; k < gnt_dly; k++) begin
          @(negedge clock);
          if (dm_req !== 1'b1) begin ok = 1'b0; break; end
          if (dm_addr !== a || dm_we !== w || dm_wdata !== d) unstable = unstable + 1;
        end
        if (ok) begin
          dm_gnt = 1'b1;
          if (w) begin
            wr_cnt = wr_cnt + 1; wr_addr = a; wr_data = d; mem[a[7:0]] = d;
          end else begin
            rd_pc = p;
          end
          @(negedge clock);
          dm_gnt = 1'b0;
          if (!w) begin
            repeat (rv_dly) @(negedge clock);
            dm_rdata = mem[a[7:0]]; dm_rvalid = 1'b1;
            @(negedge clock);
            dm_rvalid = 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic run_to_end(input string nm);
    bit done = 1'b0;
    status = 2'b01;
    for (int c = 0; c < 300; c++) begin
      @(negedge clock);
      if (end_process) begin done = 1'b1; break; end
    end
    chk({nm, "_end_reached"}, done, 1'b1);
  endtask

  task automatic soft_clear();
    status = 2'b11;
    @(negedge clock);
    status = 2'b00;
    @(negedge clock);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 16'hF000;
  endtask

  typedef struct {
    logic [15:0] i3;
    logic [15:0] i4;
    logic [8:0]  a;
    logic [8:0]  b;
    logic [15:0] exp_wr;
    logic [31:0] exp_acc;
  } vec_t;

  vec_t tbl [11];

  initial begin : main
    bit done;
    logic [15:0] exp_tr [8];
    logic [15:0] exp8;

    tbl[0]  = '{16'h4280, 16'h0000, 9'd100, 9'd23,  16'd123,  32'h0};     // ADD
    tbl[1]  = '{16'h5280, 16'h0000, 9'd3,   9'd5,   16'hFFFE, 32'h0};     // SUB wraps
    tbl[2]  = '{16'h6280, 16'h0000, 9'd300, 9'd400, 16'hD4C0, 32'h0};     // MUL low half
    tbl[3]  = '{16'h8200, 16'h0000, 9'd7,   9'd0,   16'd8,    32'h0};     // INC
    tbl[4]  = '{16'h9200, 16'h0000, 9'd0,   9'd0,   16'hFFFF, 32'h0};     // DEC wraps
    tbl[5]  = '{16'h7280, 16'hC200, 9'd511, 9'd511, 16'hFC01, 32'h3FC01}; // MAC + MVA
    tbl[6]  = '{16'h7280, 16'hD000, 9'd4,   9'd6,   16'd4,    32'h0};     // MAC then CLA
    tbl[7]  = '{16'hB004, 16'h8200, 9'd9,   9'd0,   16'd9,    32'h0};     // JMP skips INC
    tbl[8]  = '{16'hE000, 16'h0000, 9'd42,  9'd1,   16'd42,   32'h0};     // reserved = NOP
    tbl[9]  = '{16'hA404, 16'h8200, 9'd1,   9'd0,   16'd2,    32'h0};     // JNZ not taken
    tbl[10] = '{16'hA404, 16'h8200, 9'd1,   9'd1,   16'd1,    32'h0};     // JNZ taken

    exp_tr = '{16'd0, 16'd1, 16'd2, 16'd1, 16'd2, 16'd1, 16'd2, 16'd3};
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[16] = 16'hBEEF;
    clear_prog();
    for (int i = 0; i < 16; i++) prog8[i] = 16'hF000;

    reset_n = 1'b0; status = 2'b00; status8 = 2'b00;
    repeat (3) @(negedge clock);
    chk("rst_pc", pc_out, 16'h0);
    chk("rst_req", dm_req, 1'b0);
    chk("rst_we", dm_we, 1'b0);
    chk("rst_addr", dm_addr, 16'h0);
    chk("rst_wdata", dm_wdata, 16'h0);
    chk("rst_acc", acc_out, 32'h0);
    chk("rst_end", end_process, 1'b0);
    chk("core_id", core_id, 2'd2);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    chk("hold_pc", pc_out, 16'h0);
    chk("hold_state", dut.state, S_IDLE);

    // Basic MAC program.
    prog[0] = 16'h1205; prog[1] = 16'h1407; prog[2] = 16'h7280;
    prog[3] = 16'hC600; prog[4] = 16'h3640; prog[5] = 16'hF000;
    wr_cnt = 0;
    run_to_end("mac_prog");
    chk("mac_wr_cnt", wr_cnt, 1);
    chk("mac_wr_addr", wr_addr, 16'd5);
    chk("mac_wr_data", wr_data, 16'd35);
    chk("mac_acc", acc_out, 32'd35);
    status = 2'b11;
    @(negedge clock);
    status = 2'b00;
    chk("sc_end", end_process, 1'b0);
    chk("sc_pc", pc_out, 16'h0);
    chk("sc_acc", acc_out, 32'h0);
    chk("sc_state", dut.state, S_IDLE);
    @(negedge clock);

    // Table of single-operation programs.
    for (int v = 0; v < 11; v++) begin
      clear_prog();
      prog[0] = 16'h1200 | {7'd0, tbl[v].a};
      prog[1] = 16'h1400 | {7'd0, tbl[v].b};
      prog[2] = tbl[v].i3;
      prog[3] = tbl[v].i4;
      prog[4] = 16'h3200;
      prog[5] = 16'hF000;
      wr_cnt = 0;
      run_to_end($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_wr_cnt", v), wr_cnt, 1);
      chk($sformatf("vec%0d_wr_data", v), wr_data, tbl[v].exp_wr);
      chk($sformatf("vec%0d_acc", v), acc_out, tbl[v].exp_acc);
      soft_clear();
    end

    // LD with delayed grant and delayed read data.
    clear_prog();
    prog[0] = 16'h1210; prog[1] = 16'h2840; prog[2] = 16'h3800; prog[3] = 16'hF000;
    gnt_dly = 3; rv_dly = 2; wr_cnt = 0; unstable = 0; rd_pc = 16'hFFFF;
    run_to_end("ld");
    chk("ld_req_stable", unstable, 0);
    chk("ld_pc_plus1", rd_pc, 16'd2);
    chk("ld_wr_cnt", wr_cnt, 1);
    chk("ld_rdata", wr_data, 16'hBEEF);
    gnt_dly = 0; rv_dly = 0;
    soft_clear();

    // Countdown loop.
    clear_prog();
    prog[0] = 16'h1203; prog[1] = 16'h9200; prog[2] = 16'hA201; prog[3] = 16'hF000;
    ntr = 0; rec_en = 1'b1;
    run_to_end("loop");
    rec_en = 1'b0;
    chk("loop_ntr", ntr, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("loop_pc%0d", i), trace[i], exp_tr[i]);
    chk("loop_r1", dut.regs[1], 16'h0);
    soft_clear();

    // Pause requested while ADD executes.
    clear_prog();
    prog[0] = 16'h1202; prog[1] = 16'h1403; prog[2] = 16'h4280;
    prog[3] = 16'h3200; prog[4] = 16'hF000;
    wr_cnt = 0; done = 1'b0;
    status = 2'b01;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (dut.state == S_EXEC && pc_out == 16'd3) begin done = 1'b1; break; end
    end
    chk("pause_found_exec", done, 1'b1);
    status = 2'b10;
    repeat (4) @(negedge clock);
    chk("pause_state", dut.state, S_FETCH);
    chk("pause_pc", pc_out, 16'd3);
    chk("pause_add", dut.regs[1], 16'd5);
    chk("pause_req", dm_req, 1'b0);
    run_to_end("pause");
    chk("pause_wr", wr_data, 16'd5);
    soft_clear();

    // Reset in the middle of a pending store.
    clear_prog();
    prog[0] = 16'h1205; prog[1] = 16'h3240; prog[2] = 16'hF000;
    gnt_dly = 8; wr_cnt = 0; done = 1'b0;
    status = 2'b01;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (dm_req) begin done = 1'b1; break; end
    end
    chk("rstmem_found_req", done, 1'b1);
    reset_n = 1'b0; status = 2'b00;
    #1;
    chk("rstmem_req", dm_req, 1'b0);
    chk("rstmem_pc", pc_out, 16'h0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (12) @(negedge clock);
    chk("rstmem_no_write", wr_cnt, 0);
    chk("rstmem_idle", dut.state, S_IDLE);
    gnt_dly = 0;

    // 8-bit core: 255*255 accumulated twice.
    prog8[0] = 16'h12FF; prog8[1] = 16'h14FF; prog8[2] = 16'h7280;
    prog8[3] = 16'h7280; prog8[4] = 16'hF000;
`ifdef MM_CORE_MAC_SAT_EN
    exp8 = 16'hFFFF;
`else
    exp8 = 16'hFC02;
`endif
    status8 = 2'b01; done = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (end_process8) begin done = 1'b1; break; end
    end
    chk("w8_end_reached", done, 1'b1);
    chk("w8_acc", acc_out8, exp8);
    chk("w8_no_req", dm_req8, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
